// File: rtl/mm_arb_pkg.sv
// mm_arb_pkg: shared definitions for the main-memory arbiter.
// Holds the FSM state encoding, port index constants, the latency
// counter width with its legal range, and a command legality helper.
// Optional feature macro used by this slice: MM_ARB_RR_EN (round-robin).
package mm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int CNT_W       = 4;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;

  // A command is legal only when exactly one of rd/wr is asserted.
  function automatic logic cmd_is_legal(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/mm_arb_pick.sv
// mm_arb_pick: combinational winner selection between the CPU port and
// the loader port. With MM_ARB_RR_EN defined, a tie goes to the port that
// did not receive the previous grant; otherwise the CPU port wins ties.
module mm_arb_pick
  import mm_arb_pkg::*;
(
  input  logic m0_req,
  input  logic m1_req,
`ifdef MM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_idx
);

  // Pick a winner; a lone requester always wins regardless of build.
  always_comb begin
    grant_valid = m0_req | m1_req;
    grant_idx   = PORT_CPU;
    if (m0_req && m1_req) begin
`ifdef MM_ARB_RR_EN
      grant_idx = ~last_grant;
`else
      grant_idx = PORT_CPU;
`endif
    end else if (m1_req) begin
      grant_idx = PORT_LDR;
    end
  end

endmodule

// File: rtl/mm_arbiter.sv
// mm_arbiter: shares one main memory between the CPU (port 0) and the
// boot/DMA loader (port 1). A granted command is latched in IDLE, the
// memory strobes are held for MEM_LAT cycles in ACCESS, and a one-cycle
// ack (plus err for an illegal command) is returned in DONE.
// Optional feature macro: MM_ARB_RR_EN selects round-robin arbitration.
module mm_arbiter
  import mm_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic              err
);

  // Out-of-range latencies are clamped so the 4-bit counter never wraps.
  localparam int LAT_CLAMPED = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                               (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_CLAMPED);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

  logic                grant_valid;
  logic                grant_idx;
  logic                sel_rd;
  logic                sel_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

`ifdef MM_ARB_RR_EN
  logic last_grant_q, last_grant_d;
`endif

  mm_arb_pick u_pick (
    .m0_req      (m0_req),
    .m1_req      (m1_req),
`ifdef MM_ARB_RR_EN
    .last_grant  (last_grant_q),
`endif
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifdef MM_ARB_RR_EN
  // Remember who was granted last so the next tie goes the other way.
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ST_IDLE && grant_valid) begin
      last_grant_d = grant_idx;
    end
  end

  // Reset to the loader so the CPU wins the very first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= PORT_LDR;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Route the winning port's command fields toward the latch registers.
  always_comb begin
    sel_rd    = m0_rd;
    sel_wr    = m0_wr;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (grant_idx == PORT_LDR) begin
      sel_rd    = m1_rd;
      sel_wr    = m1_wr;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // Next-state logic: latch in IDLE, count down in ACCESS, ack in DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          rd_d    = sel_rd;
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          if (cmd_is_legal(sel_rd, sel_wr)) begin
            cnt_d   = CNT_LOAD;
            state_d = ST_ACCESS;
          end else begin
            // Illegal command skips memory entirely and clears rdata.
            cnt_d   = '0;
            state_d = ST_DONE;
            if (grant_idx == PORT_CPU) begin
              m0_rdata_d = '0;
            end else begin
              m1_rdata_d = '0;
            end
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          if (rd_q) begin
            if (owner_q == PORT_CPU) begin
              m0_rdata_d = mem_rdata;
            end else begin
              m1_rdata_d = mem_rdata;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= PORT_CPU;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Outputs decode straight from state so reset drops strobes at once.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    err       = 1'b0;
    busy      = (state_q != ST_IDLE);
    owner     = owner_q;
    m0_rdata  = m0_rdata_q;
    m1_rdata  = m1_rdata_q;
    if (state_q == ST_ACCESS) begin
      mem_rd    = rd_q;
      mem_wr    = wr_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
    if (state_q == ST_DONE) begin
      m0_ack = (owner_q == PORT_CPU);
      m1_ack = (owner_q == PORT_LDR);
      err    = ~cmd_is_legal(rd_q, wr_q);
    end
  end

endmodule

// File: tb/tb_mm_arbiter.sv
// tb_mm_arbiter: directed plus randomized bench for mm_arbiter.
// A behavioural memory answers the DUT's strobes; a transaction-level
// reference (pending commands per port, a reference memory image and the
// arbitration rule) predicts grants, strobe windows, acks and rdata.
// Honours MM_ARB_RR_EN the same way the design does.
module tb_mm_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_rd, m0_wr;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m0_ack;
  logic          m1_req, m1_rd, m1_wr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          m1_ack;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, owner, err;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit          pend;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t        pc [2];
  logic [31:0] expRd [2];
  bit   [31:0] refMem [64];
  bit          refVld [64];
  bit          lastOwner;
`ifdef MM_ARB_RR_EN
  bit          lastG;
`endif

  bit   [31:0] memArr [64];
  bit          memVld [64];

  always #5 clk = ~clk;

  mm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .err(err)
  );

  // Power-up contents of the memory; word 4 (byte 0x10) holds DEADBEEF.
  function automatic logic [31:0] initPattern(input logic [5:0] idx);
    return (idx == 6'd4) ? 32'hDEADBEEF : {8'hA5, 2'b00, idx, 2'b00, idx, 2'b00, idx};
  endfunction

  // Memory model: data valid whenever addressed, writes land on the edge.
  assign mem_rdata = memVld[mem_addr[7:2]] ? memArr[mem_addr[7:2]] : initPattern(mem_addr[7:2]);

  always @(posedge clk) begin
    if (mem_wr) begin
      memArr[mem_addr[7:2]] <= mem_wdata;
      memVld[mem_addr[7:2]] <= 1'b1;
    end
  end

  function automatic logic [31:0] refRead(input logic [31:0] addr);
    return refVld[addr[7:2]] ? refMem[addr[7:2]] : initPattern(addr[7:2]);
  endfunction

  task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic a0, input logic a1, input logic e,
                             input logic expBusy, input logic expOwner);
    checkBit({tag, "_ack0"}, a0, a1 ? 1'b0 : a0);
    checkBit({tag, "_err"}, err, e);
    checkBit({tag, "_busy"}, busy, expBusy);
    checkBit({tag, "_owner"}, owner, expOwner);
    checkWord({tag, "_rdata0"}, m0_rdata, expRd[0]);
    checkWord({tag, "_rdata1"}, m1_rdata, expRd[1]);
  endtask

  task automatic applyStimulus();
    m0_req = pc[0].pend; m0_rd = pc[0].rd; m0_wr = pc[0].wr;
    m0_addr = pc[0].addr; m0_wdata = pc[0].wdata;
    m1_req = pc[1].pend; m1_rd = pc[1].rd; m1_wr = pc[1].wr;
    m1_addr = pc[1].addr; m1_wdata = pc[1].wdata;
  endtask

  task automatic newCmd(input int p, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
    pc[p].pend = 1'b1; pc[p].rd = rd; pc[p].wr = wr;
    pc[p].addr = addr; pc[p].wdata = wdata;
  endtask

  // Mostly legal commands, with both illegal encodings mixed in.
  task automatic newRandomCmd(input int p);
    int r;
    r = $urandom_range(0, 9);
    newCmd(p, (r == 0) || (r >= 2 && r <= 5), (r == 0) || (r >= 6),
           $urandom & 32'hFFFF_00FC, $urandom);
  endtask

  function automatic bit pickWinner();
    if (pc[0].pend && pc[1].pend) begin
`ifdef MM_ARB_RR_EN
      return !lastG;
`else
      return 1'b0;
`endif
    end
    return pc[1].pend && !pc[0].pend;
  endfunction

  task automatic resetModel();
    expRd[0] = '0; expRd[1] = '0;
    lastOwner = 1'b0;
`ifdef MM_ARB_RR_EN
    lastG = 1'b1;
`endif
  endtask

  // One full transaction; entered #1 after an edge with the DUT in IDLE.
  task automatic runTxn();
    bit w;
    bit legal;
    applyStimulus();
    w = pickWinner();
    legal = pc[w].rd ^ pc[w].wr;
    @(negedge clk);
    checkBit("idle_strobe", mem_rd | mem_wr, 1'b0);
    checkBit("idle_ack", m0_ack | m1_ack, 1'b0);
    checkOutput("idle", m0_ack, m1_ack, 1'b0, 1'b0, lastOwner);
    @(posedge clk); #1;
    // Winner's command fields are don't-care once sampled.
    if (w == 1'b0) begin
      m0_rd = 1'($urandom); m0_wr = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
    end else begin
      m1_rd = 1'($urandom); m1_wr = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
    end
    if (legal) begin
      for (int c = 1; c <= LAT; c++) begin
        @(negedge clk);
        checkBit("acc_mem_rd", mem_rd, pc[w].rd);
        checkBit("acc_mem_wr", mem_wr, pc[w].wr);
        checkWord("acc_mem_addr", mem_addr, pc[w].addr);
        checkWord("acc_mem_wdata", mem_wdata, pc[w].wdata);
        checkBit("acc_ack", m0_ack | m1_ack, 1'b0);
        checkOutput("acc", m0_ack, m1_ack, 1'b0, 1'b1, w);
        @(posedge clk); #1;
      end
    end
    if (!legal) expRd[w] = '0;
    else if (pc[w].rd) expRd[w] = refRead(pc[w].addr);
    else begin
      refMem[pc[w].addr[7:2]] = pc[w].wdata;
      refVld[pc[w].addr[7:2]] = 1'b1;
    end
    @(negedge clk);
    checkBit("done_m0_ack", m0_ack, w == 1'b0);
    checkBit("done_m1_ack", m1_ack, w == 1'b1);
    checkBit("done_strobe", mem_rd | mem_wr, 1'b0);
    checkOutput("done", m0_ack, m1_ack, !legal, 1'b1, w);
    lastOwner = w;
`ifdef MM_ARB_RR_EN
    lastG = w;
`endif
    pc[w].pend = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      pc[p].pend = 1'b0; pc[p].rd = 1'b0; pc[p].wr = 1'b0;
      pc[p].addr = '0; pc[p].wdata = '0;
    end
    resetModel();

    // Reset with a request already pending: everything must stay at 0.
    rst = 1'b1;
    newCmd(0, 1'b1, 1'b0, 32'h10, 32'h0);
    applyStimulus();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkBit("rst_mem_rd", mem_rd, 1'b0);
    checkBit("rst_mem_wr", mem_wr, 1'b0);
    checkWord("rst_mem_addr", mem_addr, '0);
    checkWord("rst_mem_wdata", mem_wdata, '0);
    checkBit("rst_m0_ack", m0_ack, 1'b0);
    checkBit("rst_m1_ack", m1_ack, 1'b0);
    checkOutput("rst", m0_ack, m1_ack, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] CPU read of 0x10");
    runTxn();
    checkWord("cpu_read_value", m0_rdata, 32'hDEADBEEF);

    $display("[TB] loader write 0x12345678 to 0x20");
    newCmd(1, 1'b0, 1'b1, 32'h20, 32'h12345678);
    runTxn();

    $display("[TB] illegal commands on both ports");
    newCmd(0, 1'b1, 1'b1, 32'h40, 32'h0);
    runTxn();
    newCmd(1, 1'b0, 1'b0, 32'h44, 32'h0);
    runTxn();

    $display("[TB] read back loader write");
    newCmd(0, 1'b1, 1'b0, 32'h20, 32'h0);
    runTxn();

    $display("[TB] simultaneous reads, both ports re-requesting");
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pc[p].pend) newCmd(p, 1'b1, 1'b0, 32'(($urandom_range(0, 63)) * 4), 32'h0);
      runTxn();
    end
    pc[0].pend = 1'b0;
    pc[1].pend = 1'b0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 80; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pc[p].pend && $urandom_range(0, 2) != 0) newRandomCmd(p);
      if (!pc[0].pend && !pc[1].pend) begin
        applyStimulus();
        @(negedge clk);
        checkBit("gap_busy", busy, 1'b0);
        checkBit("gap_ack", m0_ack | m1_ack, 1'b0);
        @(posedge clk); #1;
      end else begin
        runTxn();
      end
    end
    pc[0].pend = 1'b0;
    pc[1].pend = 1'b0;

    $display("[TB] reset in the second ACCESS cycle");
    applyStimulus();
    @(negedge clk);
    newCmd(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    applyStimulus();
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkBit("midrst_before", mem_rd, 1'b1);
    rst = 1'b1;
    #1;
    checkBit("midrst_mem_rd", mem_rd, 1'b0);
    checkBit("midrst_busy", busy, 1'b0);
    checkBit("midrst_ack", m0_ack, 1'b0);
    pc[0].pend = 1'b0;
    applyStimulus();
    resetModel();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      checkBit("postrst_strobe", mem_rd | mem_wr, 1'b0);
      checkBit("postrst_ack", m0_ack | m1_ack, 1'b0);
      checkOutput("postrst", m0_ack, m1_ack, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;

    $display("[TB] first transaction after reset");
    newCmd(1, 1'b1, 1'b0, 32'h20, 32'h0);
    runTxn();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mm_arbiter.md
# mm_arbiter

Two-port arbiter that shares the single main memory between the CPU (control section / datapath) and a second bus master, the boot/DMA loader. It latches one requester's command, drives the memory `rd`/`wr`/address/data lines for a fixed latency, and captures read data. It then returns a one-cycle `ack`, which feeds the control section's `ack` input on port 0. It sits between the masters and `main_memory` at the system top level.

## Interface

**Parameters**
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MEM_LAT`, default 1: cycles from memory strobe to valid `mem_rdata`. Legal range is 1..15.

**Ports** (clock and reset first)
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `m0_req`  in  1: CPU request; held until `m0_ack`.
- `m0_rd`, `m0_wr`  in  1 each: command; sampled with `m0_req`.
- `m0_addr`  in  ADDR_W: byte address.
- `m0_wdata`  in  DATA_W: write data.
- `m0_rdata`  out  DATA_W: registered read data.
- `m0_ack`  out  1: one-cycle completion pulse.
- `m1_req`, `m1_rd`, `m1_wr`, `m1_addr`, `m1_wdata`, `m1_rdata`, `m1_ack`: loader port; identical semantics to port 0.
- `mem_rd`, `mem_wr`  out  1 each: memory strobes.
- `mem_addr`  out  ADDR_W: address to memory.
- `mem_wdata`  out  DATA_W: write data to memory.
- `mem_rdata`  in  DATA_W: read data from memory.
- `busy`  out  1: high in any state other than IDLE.
- `owner`  out  1: port index of the current or last grant.
- `err`  out  1: one-cycle pulse on an illegal command.

## Operation

**States:** IDLE, ACCESS, DONE.

**IDLE**
- If any `req` is high, select the winner.
- Latch the winner's rd, wr, addr and wdata into internal registers, and set `owner`.
- For a legal command (exactly one of rd/wr high), load `cnt = MEM_LAT` and go to ACCESS.
- For an illegal command (rd and wr both high, or neither), go directly to DONE with `err` set. No memory strobe is issued.

**ACCESS**
- `mem_rd`/`mem_wr`/`mem_addr`/`mem_wdata` are driven from the latched registers. Strobes are low in every other state.
- `cnt` decrements every cycle.
- At `cnt == 1`, a read captures `mem_rdata` into the owner's `rdata`, then the FSM goes to DONE.

**DONE**
- The owner's `ack` is high for exactly this cycle. `err` pulses here if the command was illegal.
- The FSM then returns to IDLE.

**Data and handshake rules**
- An illegal command sets the owner's `rdata` to 0.
- A write leaves `rdata` unchanged. `rdata` holds its value until the next read completes on that port.
- A requester must drop `req` in the cycle after it sees `ack`. If `req` is still high in IDLE, it is a new transaction.
- Command and data inputs are don't-care after the IDLE sample.
- Requests arriving during ACCESS or DONE wait; no request is lost while `req` is held.
- The losing port stays pending and is granted on the next IDLE cycle.

**Arbitration without `MM_ARB_RR_EN`:** fixed priority, port 0 (CPU) always wins ties.

**Reset:** asynchronous. State goes to IDLE, and every output is 0 (`mem_*`, `m*_rdata`, `m*_ack`, `busy`, `owner`, `err`). `cnt = 0`. Reset mid-ACCESS drops the strobes immediately, and no ack is issued for the aborted transaction.

## Timing

- Request sampled in IDLE at cycle 0 → strobes high in cycles 1..MEM_LAT → ack in cycle MEM_LAT+1.
- Illegal command: ack and err in cycle 1.
- Back-to-back throughput is one transaction per MEM_LAT+2 cycles. IDLE is always visited for one cycle between transactions.
- `owner` changes only on the IDLE→ACCESS or IDLE→DONE edge.
- With `MEM_LAT = 1`, `mem_rdata` is sampled at the end of the single ACCESS cycle. This matches a memory whose `data_out` is valid in the cycle the strobe is high.

## Configuration

**Macro: `MM_ARB_RR_EN`**
- **Defined:** round-robin arbitration. A `last_grant` register resets to 1, so port 0 wins the first tie. On simultaneous requests in IDLE, the port that is not `last_grant` wins, and `last_grant` updates on every grant.
- **Undefined:** fixed priority with port 0 first. `last_grant` is not implemented.
- Single-requester behaviour is identical in both builds.

## Structure

**Package `mm_arb_pkg`:**
- State encoding: IDLE=0, ACCESS=1, DONE=2.
- Port index constants: `PORT_CPU=0`, `PORT_LDR=1`.
- Counter width: 4 bits.
- `MEM_LAT` legality bounds.

**Sub-module `mm_arb_pick`:**
- Combinational winner selection from `m0_req`, `m1_req` and (when `MM_ARB_RR_EN` is defined) `last_grant`.
- Outputs are `grant_valid` and `grant_idx`.
- The macro is confined to this module plus the `last_grant` register.

## Test plan

1. **Reset, CPU read:** reset held, then released; `m0_req`/`m0_rd` with addr 0x10, memory returns 0xDEADBEEF, `MEM_LAT=1` → `mem_rd` high in cycle 1, `m0_ack` in cycle 2, `m0_rdata` = 0xDEADBEEF. All outputs are 0 during reset.
2. **Loader write:** `m1_wr`, addr 0x20, wdata 0x12345678 → `mem_wr` high for MEM_LAT cycles with those values, `m1_ack` pulses, `m1_rdata` unchanged.
3. **Simultaneous requests:** both ports request reads repeatedly.
   - Fixed build: port 0 is granted every time while it keeps re-requesting.
   - `MM_ARB_RR_EN` build: grants alternate 0,1,0,1.
4. **Illegal command:** `m0_rd=1` and `m0_wr=1` → no strobe, `m0_ack` and `err` in cycle 1, `m0_rdata` = 0.
5. **Reset mid-operation:** `MEM_LAT=4`, `rst` asserted in the 2nd ACCESS cycle → strobes drop the same cycle, no ack, IDLE after release.
6. **Held request:** `req` held high after ack → a second identical transaction starts after one IDLE cycle, with ack at cycle MEM_LAT+2 after the first ack.
